// File: rtl/corefifo_fwft_packer_if.sv
// FWFT read-port and packed output stream bundle for corefifo_fwft_packer.
// The master side is the packer; the slave side is the FIFO plus downstream consumer.
interface corefifo_fwft_packer_if #(
    parameter int unsigned RWIDTH = 10,
    parameter int unsigned PACK   = 4
);
    localparam int unsigned CW = $clog2(PACK + 1);
    localparam int unsigned DW = RWIDTH * PACK;

    logic              fifo_empty;
    logic [RWIDTH-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [CW-1:0]     m_count;
    logic              m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_count, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_count, m_last
    );
endinterface

// File: rtl/corefifo_fwft_packer.sv
// Drains an FWFT FIFO read port, packs PACK words per wide beat and emits beats
// through a single output register; flush closes a partial beat early.
module corefifo_fwft_packer #(
    parameter int unsigned RWIDTH   = 10,
    parameter int unsigned PACK     = 4,
    parameter int unsigned READ_LOW = 1
) (
    input  logic                   pos_rclk,
    input  logic                   aresetn_rclk,
    input  logic                   sresetn_rclk,
    input  logic                   flush,
    output logic [15:0]            words_rd,
    corefifo_fwft_packer_if.master bus
);
    localparam int unsigned CW = $clog2(PACK + 1);
    localparam int unsigned DW = RWIDTH * PACK;

    logic [DW-1:0] acc_data, acc_data_nxt;
    logic [CW-1:0] acc_cnt, acc_cnt_nxt;
    logic          flush_pending, flush_pending_nxt;
    logic          out_valid, out_valid_nxt;
    logic [DW-1:0] out_data, out_data_nxt;
    logic [CW-1:0] out_count, out_count_nxt;
    logic          out_last, out_last_nxt;
    logic [15:0]   rd_count, rd_count_nxt;

    logic          out_free;
    logic          acc_full;
    logic          xfer;
    logic          pop;
    logic [CW-1:0] slot;

    // Pop/transfer decision; the reset gate keeps the acknowledge inactive while in reset.
    always_comb begin
        out_free = !out_valid || bus.m_ready;
        acc_full = (acc_cnt == CW'(PACK));
        xfer     = out_free && (acc_full || (flush_pending && (acc_cnt != '0)));
        pop      = aresetn_rclk && sresetn_rclk && !bus.fifo_empty && !flush_pending
                   && (!acc_full || xfer);
    end

    always_comb begin
        acc_data_nxt      = xfer ? '0 : acc_data;
        acc_cnt_nxt       = xfer ? '0 : acc_cnt;
        slot              = xfer ? '0 : acc_cnt;
        flush_pending_nxt = flush_pending ? !(xfer || (acc_cnt == '0)) : flush;
        out_valid_nxt     = out_valid;
        out_data_nxt      = out_data;
        out_count_nxt     = out_count;
        out_last_nxt      = out_last;
        rd_count_nxt      = rd_count;

        // A pop that coincides with a transfer lands in slot 0 of the fresh accumulator.
        for (int unsigned i = 0; i < PACK; i++) begin
            if (pop && (slot == CW'(i))) begin
                acc_data_nxt[i*RWIDTH +: RWIDTH] = bus.fifo_dout;
            end
        end
        if (pop) begin
            acc_cnt_nxt  = slot + CW'(1);
            rd_count_nxt = rd_count + 16'd1;
        end

        if (xfer) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = acc_data;
            out_count_nxt = acc_cnt;
            out_last_nxt  = flush_pending;
        end else if (bus.m_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (!sresetn_rclk) begin
            acc_data_nxt      = '0;
            acc_cnt_nxt       = '0;
            flush_pending_nxt = 1'b0;
            out_valid_nxt     = 1'b0;
            out_data_nxt      = '0;
            out_count_nxt     = '0;
            out_last_nxt      = 1'b0;
            rd_count_nxt      = '0;
        end
    end

    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            acc_data      <= '0;
            acc_cnt       <= '0;
            flush_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_count     <= '0;
            out_last      <= 1'b0;
            rd_count      <= '0;
        end else begin
            acc_data      <= acc_data_nxt;
            acc_cnt       <= acc_cnt_nxt;
            flush_pending <= flush_pending_nxt;
            out_valid     <= out_valid_nxt;
            out_data      <= out_data_nxt;
            out_count     <= out_count_nxt;
            out_last      <= out_last_nxt;
            rd_count      <= rd_count_nxt;
        end
    end

    assign bus.fifo_rd_en = (READ_LOW != 0) ? !pop : pop;
    assign bus.m_valid    = out_valid;
    assign bus.m_data     = out_data;
    assign bus.m_count    = out_count;
    assign bus.m_last     = out_last;
    assign words_rd       = rd_count;
endmodule

// File: tb/tb_corefifo_fwft_packer.sv
// Bench for corefifo_fwft_packer: FWFT FIFO source model, word-group reference model
// and per-scenario tasks with directed and randomized traffic.
module tb_corefifo_fwft_packer;
    localparam int unsigned RW = 8;
    localparam int unsigned PK = 4;
    localparam int unsigned RL = 0;
    localparam int unsigned CW = $clog2(PK + 1);
    localparam int unsigned DW = RW * PK;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
    } beat_t;

    logic        pos_rclk;
    logic        aresetn_rclk;
    logic        sresetn_rclk;
    logic        flush;
    logic [15:0] words_rd;

    corefifo_fwft_packer_if #(.RWIDTH(RW), .PACK(PK)) bus ();

    corefifo_fwft_packer #(.RWIDTH(RW), .PACK(PK), .READ_LOW(RL)) dut (
        .pos_rclk     (pos_rclk),
        .aresetn_rclk (aresetn_rclk),
        .sresetn_rclk (sresetn_rclk),
        .flush        (flush),
        .words_rd     (words_rd),
        .bus          (bus)
    );

    initial pos_rclk = 1'b0;
    always #5 pos_rclk = ~pos_rclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc_no = 0;
    int last_flush = -10;
    int nopop_cyc = -10;
    int pops = 0;
    int groups = 0;
    int accepted = 0;

    logic [RW-1:0] src[$];
    logic [RW-1:0] cur[$];
    beat_t         exp_q[$];

    bit            o_pop;
    bit            o_valid;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;
    logic          o_last;

    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic [CW-1:0] prev_count;
    logic          prev_last;

    function automatic beat_t mk_beat(input bit last);
        beat_t b;
        b.data = '0;
        foreach (cur[i]) b.data[i*RW +: RW] = cur[i];
        b.cnt  = CW'(cur.size());
        b.last = last;
        return b;
    endfunction

    function automatic bit can_flush(input bit stl);
        return (cyc_no - last_flush >= 2) && (groups == accepted)
               && (stl || (src.size() == 0) || (cur.size() <= int'(PK) - 2));
    endfunction

    function automatic bit rd_active();
        return (RL != 0) ? !bus.fifo_rd_en : bus.fifo_rd_en;
    endfunction

    task automatic model_clear();
        src.delete();
        cur.delete();
        exp_q.delete();
        pops = 0;
        groups = 0;
        accepted = 0;
        prev_hold = 1'b0;
        nopop_cyc = -10;
    endtask

    // One clock cycle: drive at posedge+1, sample and score at negedge, retire the FIFO head after the edge.
    task automatic cyc(input bit stall, input bit rdy, input bit fl);
        beat_t e;
        bus.fifo_empty = stall || (src.size() == 0);
        bus.fifo_dout  = (src.size() != 0) ? src[0] : '0;
        bus.m_ready    = rdy;
        flush          = fl;
        @(negedge pos_rclk);
        o_pop   = rd_active();
        o_valid = bus.m_valid;
        o_data  = bus.m_data;
        o_count = bus.m_count;
        o_last  = bus.m_last;

        n_vec++;
        if (words_rd !== 16'(pops)) begin
            n_err++;
            $display("FAIL words_rd cyc %0d: got %0d want %0d", cyc_no, words_rd, pops);
        end
        n_vec++;
        if (o_pop && bus.fifo_empty) begin
            n_err++;
            $display("FAIL pop_on_empty cyc %0d: got rd_en active want inactive", cyc_no);
        end
        if (cyc_no == nopop_cyc) begin
            n_vec++;
            if (o_pop) begin
                n_err++;
                $display("FAIL pop_in_flush cyc %0d: got rd_en active want inactive", cyc_no);
            end
        end
        if (prev_hold) begin
            n_vec++;
            if (!o_valid || o_data !== prev_data || o_count !== prev_count || o_last !== prev_last) begin
                n_err++;
                $display("FAIL hold cyc %0d: got v=%0b d=%h c=%0d l=%0b want v=1 d=%h c=%0d l=%0b",
                         cyc_no, o_valid, o_data, o_count, o_last, prev_data, prev_count, prev_last);
            end
        end
        if (o_valid && rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat cyc %0d: got unexpected beat d=%h want none", cyc_no, o_data);
            end else begin
                e = exp_q.pop_front();
                accepted++;
                if (o_data !== e.data || o_count !== e.cnt || o_last !== e.last) begin
                    n_err++;
                    $display("FAIL beat cyc %0d: got d=%h c=%0d l=%0b want d=%h c=%0d l=%0b",
                             cyc_no, o_data, o_count, o_last, e.data, e.cnt, e.last);
                end
            end
        end

        if (o_pop && !bus.fifo_empty) begin
            cur.push_back(bus.fifo_dout);
            pops++;
            if (cur.size() == int'(PK)) begin
                exp_q.push_back(mk_beat(1'b0));
                cur.delete();
                groups++;
            end
        end
        if (fl) begin
            if (cur.size() != 0) begin
                exp_q.push_back(mk_beat(1'b1));
                cur.delete();
                groups++;
            end
            nopop_cyc  = cyc_no + 1;
            last_flush = cyc_no;
        end
        prev_hold  = o_valid && !rdy;
        prev_data  = o_data;
        prev_count = o_count;
        prev_last  = o_last;

        @(posedge pos_rclk);
        #1;
        if (o_pop && !bus.fifo_empty) void'(src.pop_front());
        flush = 1'b0;
        cyc_no++;
    endtask

    task automatic test_reset();
        aresetn_rclk   = 1'b0;
        sresetn_rclk   = 1'b1;
        flush          = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.fifo_dout  = 8'hA5;
        bus.m_ready    = 1'b1;
        #2;
        n_vec++;
        if (rd_active()) begin n_err++; $display("FAIL reset_rd_en: got active want inactive"); end
        n_vec++;
        if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        n_vec++;
        if (bus.m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
        n_vec++;
        if (bus.m_count !== '0) begin n_err++; $display("FAIL reset_m_count: got %0d want 0", bus.m_count); end
        n_vec++;
        if (bus.m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        n_vec++;
        if (words_rd !== 16'd0) begin n_err++; $display("FAIL reset_words_rd: got %0d want 0", words_rd); end
        bus.fifo_empty = 1'b1;
        #20;
        aresetn_rclk = 1'b1;
        @(posedge pos_rclk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] pm, vm;
        logic [DW-1:0] d5;
        logic [CW-1:0] c5;
        logic l5;
        logic [15:0] w0;
        pm = '0; vm = '0; d5 = '0; c5 = '0; l5 = 1'b1; w0 = words_rd;
        src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33); src.push_back(8'h44);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            pm[c] = o_pop;
            vm[c] = o_valid;
            if (c == 5) begin d5 = o_data; c5 = o_count; l5 = o_last; end
        end
        n_vec++;
        if (pm !== 32'h0000_000F) begin n_err++; $display("FAIL basic_pops: got %h want 0000000f", pm); end
        n_vec++;
        if (vm !== 32'h0000_0020) begin n_err++; $display("FAIL basic_valid: got %h want 00000020", vm); end
        n_vec++;
        if (d5 !== DW'(32'h4433_2211)) begin n_err++; $display("FAIL basic_data: got %h want 44332211", d5); end
        n_vec++;
        if (c5 !== CW'(4)) begin n_err++; $display("FAIL basic_count: got %0d want 4", c5); end
        n_vec++;
        if (l5 !== 1'b0) begin n_err++; $display("FAIL basic_last: got %b want 0", l5); end
        n_vec++;
        if (words_rd - w0 !== 16'd4) begin n_err++; $display("FAIL basic_words_rd: got %0d want 4", words_rd - w0); end
    endtask

    task automatic test_stream();
        logic [31:0] pm, vm;
        pm = '0; vm = '0;
        for (int i = 0; i < 12; i++) src.push_back(RW'($urandom_range(255)));
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            pm[c] = o_pop;
            vm[c] = o_valid;
        end
        n_vec++;
        if (pm !== 32'h0000_0FFF) begin n_err++; $display("FAIL stream_pops: got %h want 00000fff", pm); end
        n_vec++;
        if (vm !== 32'h0000_2220) begin n_err++; $display("FAIL stream_valid: got %h want 00002220", vm); end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] w[12];
        logic [DW-1:0] e0, e1;
        logic [31:0] pm, vm;
        pm = '0; vm = '0; e0 = '0; e1 = '0;
        for (int i = 0; i < 12; i++) begin
            w[i] = RW'($urandom_range(255));
            src.push_back(w[i]);
        end
        for (int i = 0; i < int'(PK); i++) begin
            e0[i*RW +: RW] = w[i];
            e1[i*RW +: RW] = w[i+4];
        end
        for (int c = 0; c < 14; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            pm[c] = o_pop;
            vm[c] = o_valid;
        end
        n_vec++;
        if (pm !== 32'h0000_00FF) begin n_err++; $display("FAIL bp_pops: got %h want 000000ff", pm); end
        n_vec++;
        if (vm !== 32'h0000_3FE0) begin n_err++; $display("FAIL bp_valid: got %h want 00003fe0", vm); end
        n_vec++;
        if (o_data !== e0) begin n_err++; $display("FAIL bp_held_data: got %h want %h", o_data, e0); end
        cyc(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (!o_pop) begin n_err++; $display("FAIL bp_resume: got rd_en inactive want active"); end
        cyc(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (!o_valid || o_data !== e1) begin
            n_err++;
            $display("FAIL bp_second_beat: got v=%0b d=%h want v=1 d=%h", o_valid, o_data, e1);
        end
        for (int c = 0; c < 9; c++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        logic [31:0] pm, vm;
        logic [DW-1:0] d6;
        logic [CW-1:0] c6;
        logic l6;
        logic [15:0] w0;
        pm = '0; vm = '0; d6 = '0; c6 = '0; l6 = 1'b0; w0 = words_rd;
        src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
        for (int c = 0; c < 14; c++) begin
            cyc((c == 3) || (c == 4), 1'b1, (c == 4));
            pm[c] = o_pop;
            vm[c] = o_valid;
            if (c == 4) begin
                src.push_back(8'h55); src.push_back(8'h66); src.push_back(8'h77); src.push_back(8'h88);
            end
            if (c == 6) begin d6 = o_data; c6 = o_count; l6 = o_last; end
        end
        n_vec++;
        if (pm !== 32'h0000_03C7) begin n_err++; $display("FAIL flush_pops: got %h want 000003c7", pm); end
        n_vec++;
        if (vm !== 32'h0000_0840) begin n_err++; $display("FAIL flush_valid: got %h want 00000840", vm); end
        n_vec++;
        if (d6 !== DW'(32'h0033_2211) || c6 !== CW'(3) || l6 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_beat: got d=%h c=%0d l=%0b want d=00332211 c=3 l=1", d6, c6, l6);
        end
        n_vec++;
        if (words_rd - w0 !== 16'd7) begin n_err++; $display("FAIL flush_words_rd: got %0d want 7", words_rd - w0); end
    endtask

    task automatic test_flush_empty();
        logic [31:0] pm, vm;
        logic [CW-1:0] c7;
        logic l7;
        pm = '0; vm = '0; c7 = '0; l7 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc((c == 0), 1'b1, (c == 0));
            pm[c] = o_pop;
            vm[c] = o_valid;
            if (c == 0) for (int i = 0; i < 4; i++) src.push_back(RW'($urandom_range(255)));
            if (c == 7) begin c7 = o_count; l7 = o_last; end
        end
        n_vec++;
        if (pm !== 32'h0000_003C) begin n_err++; $display("FAIL flush0_pops: got %h want 0000003c", pm); end
        n_vec++;
        if (vm !== 32'h0000_0080) begin n_err++; $display("FAIL flush0_valid: got %h want 00000080", vm); end
        n_vec++;
        if (c7 !== CW'(4) || l7 !== 1'b0) begin
            n_err++;
            $display("FAIL flush0_beat: got c=%0d l=%0b want c=4 l=0", c7, l7);
        end
    endtask

    // Leaves two words in the accumulator behind a held beat.
    task automatic build_mid_beat();
        for (int i = 0; i < 6; i++) src.push_back(RW'($urandom_range(255)));
        for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (!o_valid) begin n_err++; $display("FAIL midbeat_valid: got 0 want 1"); end
    endtask

    task automatic test_async_reset();
        build_mid_beat();
        src.push_back(8'hC1); src.push_back(8'hC2);
        bus.fifo_empty = 1'b0;
        bus.fifo_dout  = src[0];
        bus.m_ready    = 1'b0;
        #1;
        n_vec++;
        if (!rd_active()) begin n_err++; $display("FAIL areset_pre_pop: got inactive want active"); end
        aresetn_rclk = 1'b0;
        #1;
        n_vec++;
        if (rd_active()) begin n_err++; $display("FAIL areset_rd_en: got active want inactive"); end
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_count !== '0 || bus.m_last !== 1'b0) begin
            n_err++;
            $display("FAIL areset_out: got v=%b d=%h c=%0d l=%b want all 0",
                     bus.m_valid, bus.m_data, bus.m_count, bus.m_last);
        end
        n_vec++;
        if (words_rd !== 16'd0) begin n_err++; $display("FAIL areset_words_rd: got %0d want 0", words_rd); end
        bus.fifo_empty = 1'b1;
        model_clear();
        #3;
        aresetn_rclk = 1'b1;
        @(posedge pos_rclk);
        #1;
    endtask

    task automatic test_sync_reset();
        logic [31:0] pm, vm;
        logic [15:0] w0;
        pm = '0; vm = '0;
        build_mid_beat();
        sresetn_rclk   = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.m_ready    = 1'b0;
        flush          = 1'b0;
        @(posedge pos_rclk);
        #1;
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_count !== '0 || bus.m_last !== 1'b0) begin
            n_err++;
            $display("FAIL sreset_out: got v=%b d=%h c=%0d l=%b want all 0",
                     bus.m_valid, bus.m_data, bus.m_count, bus.m_last);
        end
        n_vec++;
        if (words_rd !== 16'd0) begin n_err++; $display("FAIL sreset_words_rd: got %0d want 0", words_rd); end
        sresetn_rclk = 1'b1;
        model_clear();
        w0 = words_rd;
        for (int i = 0; i < 4; i++) src.push_back(RW'($urandom_range(255)));
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            pm[c] = o_pop;
            vm[c] = o_valid;
        end
        n_vec++;
        if (pm !== 32'h0000_000F || vm !== 32'h0000_0020) begin
            n_err++;
            $display("FAIL sreset_next_beat: got pops=%h valid=%h want pops=0000000f valid=00000020", pm, vm);
        end
        n_vec++;
        if (words_rd - w0 !== 16'd4) begin n_err++; $display("FAIL sreset_words_rd2: got %0d want 4", words_rd - w0); end
    endtask

    task automatic test_random();
        bit stl, rdy, fl;
        for (int k = 0; k < 600; k++) begin
            if (src.size() < 6 && $urandom_range(3) != 0) src.push_back(RW'($urandom_range(255)));
            stl = ($urandom_range(3) == 0);
            rdy = ($urandom_range(9) < 7);
            fl  = can_flush(stl) && ($urandom_range(15) == 0);
            cyc(stl, rdy, fl);
        end
        for (int k = 0; k < 400; k++) begin
            if (src.size() == 0 && cur.size() == 0 && exp_q.size() == 0) break;
            fl = can_flush(1'b0) && (src.size() == 0) && (cur.size() != 0);
            cyc(1'b0, 1'b1, fl);
        end
        n_vec++;
        if (exp_q.size() != 0 || cur.size() != 0 || src.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d beats %0d words %0d queued left want 0",
                     exp_q.size(), cur.size(), src.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_empty();
        test_async_reset();
        test_sync_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
